// File: rtl/icache_ctrl_pkg.sv
// Shared constants, FSM encoding and miss-context payload for the I-cache miss controller.
package icache_ctrl_pkg;

   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned BLOCK_BITS = 128;
   localparam int unsigned WORD_BITS  = 32;
   localparam int unsigned OFF_W      = $clog2(BLOCK_BITS / 8);
   localparam int unsigned BADDR_W    = ADDR_W - OFF_W;
   localparam int unsigned WSEL_W     = OFF_W - 2;
   localparam int unsigned NWORDS     = BLOCK_BITS / WORD_BITS;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEM_REQ = 2'd1,
      ST_FILL    = 2'd2,
      ST_RESP    = 2'd3
   } state_e;

   // Address of the outstanding miss: block address plus requested word index.
   typedef struct packed {
      logic [BADDR_W-1:0] baddr;
      logic [WSEL_W-1:0]  widx;
   } miss_ctx_t;

endpackage

// File: rtl/icache_word_sel.sv
// Combinational block-to-word mux: picks word `sel` from a cache block (word 0 = LSBs).
module icache_word_sel
   import icache_ctrl_pkg::*;
(
   input  logic [BLOCK_BITS-1:0] blk,
   input  logic [WSEL_W-1:0]     sel,
   output logic [WORD_BITS-1:0]  word_c
);

   always_comb begin
      word_c = '0;
      for (int unsigned i = 0; i < NWORDS; i++) begin
         if (sel == WSEL_W'(i)) word_c = blk[i*WORD_BITS +: WORD_BITS];
      end
   end

endmodule

// File: rtl/icache_ctrl.sv
// I-cache miss controller: lookup, block fetch from memory, array fill, word return.
// Optional hit/miss performance counters under `ICACHE_PERF_CNT_EN.
module icache_ctrl
   import icache_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic [ADDR_W-1:0]     cpu_addr,
   output logic                  cpu_stall,
   output logic [WORD_BITS-1:0]  cpu_rdata,
`ifdef ICACHE_PERF_CNT_EN
   output logic [31:0]           hit_cnt,
   output logic [31:0]           miss_cnt,
`endif
   output logic                  sram_ren,
   output logic                  sram_wen,
   output logic [BADDR_W-1:0]    sram_baddr,
   output logic [BLOCK_BITS-1:0] sram_wdata,
   input  logic                  sram_hit,
   input  logic [BLOCK_BITS-1:0] sram_rdata,
   output logic                  mem_req,
   output logic [BADDR_W-1:0]    mem_baddr,
   input  logic                  mem_ready,
   input  logic [BLOCK_BITS-1:0] mem_rdata
);

   state_e                state_q, state_d;
   miss_ctx_t             ctx_q, ctx_d;
   logic [BLOCK_BITS-1:0] fill_q, fill_d;
   logic                  mem_req_q, mem_req_d;
   logic                  sram_wen_q, sram_wen_d;
   logic [WORD_BITS-1:0]  hit_word;
   logic [WORD_BITS-1:0]  fill_word;
   logic                  unused_addr_lsb;

   // Fetches are word aligned; the byte-select bits carry no information.
   assign unused_addr_lsb = ^cpu_addr[1:0];

   icache_word_sel u_hit_sel (
      .blk    (sram_rdata),
      .sel    (cpu_addr[OFF_W-1:2]),
      .word_c (hit_word)
   );

   icache_word_sel u_fill_sel (
      .blk    (fill_q),
      .sel    (ctx_q.widx),
      .word_c (fill_word)
   );

   // State and miss-context registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         ctx_q      <= '0;
         fill_q     <= '0;
         mem_req_q  <= 1'b0;
         sram_wen_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctx_q      <= ctx_d;
         fill_q     <= fill_d;
         mem_req_q  <= mem_req_d;
         sram_wen_q <= sram_wen_d;
      end
   end

   // Next-state logic; mem_req and sram_wen are flopped from the upcoming state.
   always_comb begin
      state_d = state_q;
      ctx_d   = ctx_q;
      fill_d  = fill_q;
      case (state_q)
         ST_IDLE: begin
            if (cpu_req && !sram_hit) begin
               ctx_d.baddr = cpu_addr[ADDR_W-1:OFF_W];
               ctx_d.widx  = cpu_addr[OFF_W-1:2];
               state_d     = ST_MEM_REQ;
            end
         end
         ST_MEM_REQ: begin
            if (mem_ready) begin
               fill_d  = mem_rdata;
               state_d = ST_FILL;
            end
         end
         ST_FILL: state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      mem_req_d  = (state_d == ST_MEM_REQ);
      sram_wen_d = (state_d == ST_FILL);
   end

   // Outputs; the IDLE lookup path is combinational so hits cost no latency.
   always_comb begin
      sram_ren   = 1'b0;
      sram_baddr = ctx_q.baddr;
      cpu_stall  = 1'b0;
      cpu_rdata  = '0;
      case (state_q)
         ST_IDLE: begin
            sram_baddr = cpu_addr[ADDR_W-1:OFF_W];
            if (cpu_req && rst) begin
               sram_ren  = 1'b1;
               cpu_stall = !sram_hit;
               if (sram_hit) cpu_rdata = hit_word;
            end
         end
         ST_MEM_REQ, ST_FILL: cpu_stall = 1'b1;
         ST_RESP:             cpu_rdata = fill_word;
         default: ;
      endcase
   end

   assign sram_wen   = sram_wen_q;
   assign sram_wdata = fill_q;
   assign mem_req    = mem_req_q;
   assign mem_baddr  = ctx_q.baddr;

`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   // Count lookups only; stall cycles of a miss are not re-counted.
   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (state_q == ST_IDLE && cpu_req) begin
         if (sram_hit) hit_cnt_d  = hit_cnt_q + 32'd1;
         else          miss_cnt_d = miss_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: array and memory models, directed fetch sequence.
module tb_icache_ctrl;
   import icache_ctrl_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  cpu_req;
   logic [ADDR_W-1:0]     cpu_addr;
   logic                  cpu_stall;
   logic [WORD_BITS-1:0]  cpu_rdata;
   logic                  sram_ren, sram_wen, sram_hit;
   logic [BADDR_W-1:0]    sram_baddr;
   logic [BLOCK_BITS-1:0] sram_wdata, sram_rdata;
   logic                  mem_req;
   logic [BADDR_W-1:0]    mem_baddr;
   logic                  mem_ready = 1'b0;
   logic [BLOCK_BITS-1:0] mem_rdata = '0;
`ifdef ICACHE_PERF_CNT_EN
   logic [31:0]           hit_cnt, miss_cnt;
`endif

   icache_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req    (cpu_req),
      .cpu_addr   (cpu_addr),
      .cpu_stall  (cpu_stall),
      .cpu_rdata  (cpu_rdata),
`ifdef ICACHE_PERF_CNT_EN
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt),
`endif
      .sram_ren   (sram_ren),
      .sram_wen   (sram_wen),
      .sram_baddr (sram_baddr),
      .sram_wdata (sram_wdata),
      .sram_hit   (sram_hit),
      .sram_rdata (sram_rdata),
      .mem_req    (mem_req),
      .mem_baddr  (mem_baddr),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] data; int cyc; } resp_t;
   typedef struct { logic [27:0] baddr; logic [127:0] data; } fill_t;

   resp_t       resp_q[$];
   fill_t       fill_q[$];
   logic [27:0] mem_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          mem_lat = 0;

   localparam logic [127:0] PRE_BLK = 128'h4444_4444_3333_3333_2222_2222_1111_1111;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [127:0] mem_block(input logic [27:0] b);
      if (b == 28'h000_0200) return 128'h0123_4567_89AB_CDEF_DEAD_BEEF_CAFE_F00D;
      return {b[15:0], 16'h5A03, b[15:0], 16'h5A02, b[15:0], 16'h5A01, b[15:0], 16'h5A00};
   endfunction

   // Cache array model: one preloaded block plus blocks written by fills.
   bit [7:0]     arr_v;
   logic [27:0]  arr_a [8];
   logic [127:0] arr_d [8];
   bit [2:0]     wp;

   always_comb begin
      sram_hit   = 1'b0;
      sram_rdata = '0;
      if (sram_ren) begin
         if (sram_baddr == 28'h000_0100) begin
            sram_hit   = 1'b1;
            sram_rdata = PRE_BLK;
         end
         for (int i = 0; i < 8; i++) begin
            if (arr_v[i] && arr_a[i] == sram_baddr) begin
               sram_hit   = 1'b1;
               sram_rdata = arr_d[i];
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rst && sram_wen) begin
         arr_v[wp] <= 1'b1;
         arr_a[wp] <= sram_baddr;
         arr_d[wp] <= sram_wdata;
         wp        <= wp + 3'd1;
      end
   end

   // Memory model: answers each request after mem_lat extra cycles.
   bit          busy = 1'b0;
   int          cnt = 0;
   logic [27:0] cur = '0;

   always @(negedge clk or negedge rst) begin
      if (!rst) begin
         mem_ready = 1'b0;
         busy      = 1'b0;
         cnt       = 0;
      end else begin
         mem_ready = 1'b0;
         if (mem_req && !busy) begin
            busy = 1'b1;
            cnt  = mem_lat;
            if (mem_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL mem_req_unexpected: got baddr %0h expected no request", mem_baddr);
               cur = mem_baddr;
            end else begin
               cur = mem_q.pop_front();
            end
         end
         if (busy) begin
            chk("mem_req_held", 128'(mem_req), 128'd1);
            chk("mem_baddr", 128'(mem_baddr), 128'(cur));
            if (cnt == 0) begin
               mem_ready = 1'b1;
               mem_rdata = mem_block(cur);
               busy      = 1'b0;
            end else begin
               cnt--;
            end
         end
      end
   end

   // Monitor: compares delivered words and fills against the scoreboard queues.
   always @(negedge clk) begin
      if (rst) begin
         if (sram_ren && sram_wen) chk("ren_wen_exclusive", 128'd1, 128'd0);
         if (cpu_req && !cpu_stall) begin
            if (resp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL resp_unexpected: got %0h expected no delivery", cpu_rdata);
            end else begin
               resp_t r;
               r = resp_q.pop_front();
               chk("resp_data", 128'(cpu_rdata), 128'(r.data));
               chk("resp_cycle", 128'(cyc), 128'(r.cyc));
            end
         end
         if (sram_wen) begin
            chk("fill_ren_low", 128'(sram_ren), 128'd0);
            if (fill_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL fill_unexpected: got baddr %0h expected no fill", sram_baddr);
            end else begin
               fill_t f;
               f = fill_q.pop_front();
               chk("fill_baddr", 128'(sram_baddr), 128'(f.baddr));
               chk("fill_wdata", sram_wdata, f.data);
            end
         end
      end
   end

   task automatic access(input logic [31:0] addr, input logic [31:0] exp, input bit miss,
                         input int lat, input bit toggle);
      resp_t r;
      fill_t f;
      int    n;
      bit    done;
      @(posedge clk);
      #1;
      cpu_req  = 1'b1;
      cpu_addr = addr;
      mem_lat  = lat;
      r.data   = exp;
      r.cyc    = miss ? cyc + lat + 3 : cyc;
      resp_q.push_back(r);
      if (miss) begin
         mem_q.push_back(addr[31:4]);
         f.baddr = addr[31:4];
         f.data  = mem_block(addr[31:4]);
         fill_q.push_back(f);
      end
      n    = 0;
      done = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (n == 0) begin
            chk("lookup_ren", 128'(sram_ren), 128'd1);
            chk("lookup_baddr", 128'(sram_baddr), 128'(addr[31:4]));
            chk("lookup_stall", 128'(cpu_stall), 128'(miss));
         end
         if (!cpu_stall) begin
            done = 1'b1;
         end else begin
            if (toggle && n > 0) cpu_addr = n[0] ? 32'h0000_1008 : 32'h7777_0000;
            n++;
            if (n > 40) begin
               checks++;
               errors++;
               $display("FAIL access_timeout: addr %0h still stalled after %0d cycles", addr, n);
               done = 1'b1;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      repeat (n) @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst      = 1'b0;
      cpu_req  = 1'b1;
      cpu_addr = 32'h0000_1008;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_stall", 128'(cpu_stall), 128'd0);
      chk("reset_mem_req", 128'(mem_req), 128'd0);
      chk("reset_sram_wen", 128'(sram_wen), 128'd0);
      chk("reset_sram_ren", 128'(sram_ren), 128'd0);
      chk("reset_rdata", 128'(cpu_rdata), 128'd0);
      @(posedge clk);
      #1;
      rst     = 1'b1;
      cpu_req = 1'b0;
      repeat (2) @(posedge clk);

      access(32'h0000_1008, 32'h3333_3333, 1'b0, 0, 1'b0);
      access(32'h0000_2004, 32'hDEAD_BEEF, 1'b1, 3, 1'b0);
      access(32'h0000_2004, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
      access(32'h0000_3008, 32'h0300_5A02, 1'b1, 0, 1'b1);
      idle(2);

      // Reset while the miss is waiting on memory.
      @(posedge clk);
      #1;
      cpu_req  = 1'b1;
      cpu_addr = 32'h0000_4000;
      mem_lat  = 5;
      mem_q.push_back(28'h000_0400);
      @(negedge clk);
      @(negedge clk);
      chk("abort_mem_req_before", 128'(mem_req), 128'd1);
      #2;
      rst     = 1'b0;
      cpu_req = 1'b0;
      #1;
      chk("abort_mem_req_drop", 128'(mem_req), 128'd0);
      chk("abort_sram_wen", 128'(sram_wen), 128'd0);
      chk("abort_stall", 128'(cpu_stall), 128'd0);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst = 1'b1;
      @(negedge clk);
      chk("post_abort_stall", 128'(cpu_stall), 128'd0);
      chk("post_abort_mem_req", 128'(mem_req), 128'd0);

      access(32'h0000_1008, 32'h3333_3333, 1'b0, 0, 1'b0);
      access(32'h0000_4000, 32'h0400_5A00, 1'b1, 1, 1'b0);
      access(32'h0000_4004, 32'h0400_5A01, 1'b0, 0, 1'b0);
      access(32'h0000_2000, 32'hCAFE_F00D, 1'b0, 0, 1'b0);
      access(32'h0000_5000, 32'h0500_5A00, 1'b1, 2, 1'b0);
      access(32'h0000_500C, 32'h0500_5A03, 1'b0, 0, 1'b0);
      access(32'h0000_1004, 32'h2222_2222, 1'b0, 0, 1'b0);
      idle(4);

      chk("resp_queue_drained", 128'(resp_q.size()), 128'd0);
      chk("fill_queue_drained", 128'(fill_q.size()), 128'd0);
      chk("mem_queue_drained", 128'(mem_q.size()), 128'd0);
`ifdef ICACHE_PERF_CNT_EN
      chk("hit_cnt", 128'(hit_cnt), 128'd5);
      chk("miss_cnt", 128'(miss_cnt), 128'd2);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
